// File: rtl/rocc_cmd_queue.sv
// RoCC command queue: DEPTH-entry FIFO between core and accelerator, gates xd=1 issue on owed responses.
// Optional RCQ_STATS_EN adds push and stall counters.
module rocc_cmd_queue #(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   cpu_cmd_valid,
  output logic                                   cpu_cmd_ready,
  input  logic [6:0]                             cpu_cmd_funct,
  input  logic [4:0]                             cpu_cmd_rd,
  input  logic                                   cpu_cmd_xd,
  input  logic [63:0]                            cpu_cmd_rs1,
  input  logic [63:0]                            cpu_cmd_rs2,
  output logic                                   acc_cmd_valid,
  input  logic                                   acc_cmd_ready,
  output logic [6:0]                             acc_cmd_funct,
  output logic [4:0]                             acc_cmd_rd,
  output logic                                   acc_cmd_xd,
  output logic [63:0]                            acc_cmd_rs1,
  output logic [63:0]                            acc_cmd_rs2,
  input  logic                                   acc_resp_valid,
  input  logic                                   acc_resp_ready,
  input  logic                                   flush,
  output logic                                   busy,
  output logic [$clog2(DEPTH):0]                 level,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
  output logic                                   resp_underflow
`ifdef RCQ_STATS_EN
  ,
  output logic [31:0]                            stat_cmds,
  output logic [31:0]                            stat_stall_cycles
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  logic [6:0]  funct_mem [DEPTH];
  logic [4:0]  rd_mem    [DEPTH];
  logic        xd_mem    [DEPTH];
  logic [63:0] rs1_mem   [DEPTH];
  logic [63:0] rs2_mem   [DEPTH];

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          empty;
  logic          full;
  logic          at_limit;
  logic          push;
  logic          pop;
  logic          resp;
  logic          inc;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);

  assign acc_cmd_funct = funct_mem[rptr[AW-1:0]];
  assign acc_cmd_rd    = rd_mem[rptr[AW-1:0]];
  assign acc_cmd_xd    = xd_mem[rptr[AW-1:0]];
  assign acc_cmd_rs1   = rs1_mem[rptr[AW-1:0]];
  assign acc_cmd_rs2   = rs2_mem[rptr[AW-1:0]];

  // Only xd=1 heads wait for a free response slot; xd=0 heads always go.
  assign at_limit      = (outstanding == OW'(MAX_OUTSTANDING));
  assign acc_cmd_valid = !empty && !(acc_cmd_xd && at_limit);
  assign cpu_cmd_ready = !full;

  assign push = cpu_cmd_valid && cpu_cmd_ready;
  assign pop  = acc_cmd_valid && acc_cmd_ready;
  assign resp = acc_resp_valid && acc_resp_ready;
  assign inc  = pop && acc_cmd_xd && !flush;

  assign level = wptr - rptr;
  assign busy  = !empty || (outstanding != '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        funct_mem[i] <= '0;
        rd_mem[i]    <= '0;
        xd_mem[i]    <= 1'b0;
        rs1_mem[i]   <= '0;
        rs2_mem[i]   <= '0;
      end
    end else if (push && !flush) begin
      funct_mem[wptr[AW-1:0]] <= cpu_cmd_funct;
      rd_mem[wptr[AW-1:0]]    <= cpu_cmd_rd;
      xd_mem[wptr[AW-1:0]]    <= cpu_cmd_xd;
      rs1_mem[wptr[AW-1:0]]   <= cpu_cmd_rs1;
      rs2_mem[wptr[AW-1:0]]   <= cpu_cmd_rs2;
    end
  end

  // Responses keep draining through a flush since they are still in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      outstanding    <= '0;
      resp_underflow <= 1'b0;
    end else if (inc && !resp) begin
      outstanding <= outstanding + OW'(1);
    end else if (!inc && resp) begin
      if (outstanding == '0) resp_underflow <= 1'b1;
      else                   outstanding    <= outstanding - OW'(1);
    end
  end

`ifdef RCQ_STATS_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_cmds         <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (push)                           stat_cmds         <= stat_cmds + 32'd1;
      if (cpu_cmd_valid && !cpu_cmd_ready) stat_stall_cycles <= stat_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rocc_cmd_queue.sv
// Scoreboard bench for rocc_cmd_queue: accepted commands queue up as expectations, issued ones are checked in order.
module tb_rocc_cmd_queue;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_cmd_valid, cpu_cmd_ready;
  logic [6:0]  cpu_cmd_funct;
  logic [4:0]  cpu_cmd_rd;
  logic        cpu_cmd_xd;
  logic [63:0] cpu_cmd_rs1, cpu_cmd_rs2;
  logic        acc_cmd_valid, acc_cmd_ready;
  logic [6:0]  acc_cmd_funct;
  logic [4:0]  acc_cmd_rd;
  logic        acc_cmd_xd;
  logic [63:0] acc_cmd_rs1, acc_cmd_rs2;
  logic        acc_resp_valid, acc_resp_ready;
  logic        flush;
  logic        busy;
  logic [2:0]  level;
  logic [1:0]  outstanding;
  logic        resp_underflow;
`ifdef RCQ_STATS_EN
  logic [31:0] stat_cmds, stat_stall_cycles;
`endif

  always #5 clock = ~clock;

  rocc_cmd_queue #(.DEPTH(4), .MAX_OUTSTANDING(2)) dut (
    .clock(clock), .reset(reset),
    .cpu_cmd_valid(cpu_cmd_valid), .cpu_cmd_ready(cpu_cmd_ready),
    .cpu_cmd_funct(cpu_cmd_funct), .cpu_cmd_rd(cpu_cmd_rd), .cpu_cmd_xd(cpu_cmd_xd),
    .cpu_cmd_rs1(cpu_cmd_rs1), .cpu_cmd_rs2(cpu_cmd_rs2),
    .acc_cmd_valid(acc_cmd_valid), .acc_cmd_ready(acc_cmd_ready),
    .acc_cmd_funct(acc_cmd_funct), .acc_cmd_rd(acc_cmd_rd), .acc_cmd_xd(acc_cmd_xd),
    .acc_cmd_rs1(acc_cmd_rs1), .acc_cmd_rs2(acc_cmd_rs2),
    .acc_resp_valid(acc_resp_valid), .acc_resp_ready(acc_resp_ready),
    .flush(flush), .busy(busy), .level(level), .outstanding(outstanding),
    .resp_underflow(resp_underflow)
`ifdef RCQ_STATS_EN
    , .stat_cmds(stat_cmds), .stat_stall_cycles(stat_stall_cycles)
`endif
  );

  typedef struct packed {
    logic [6:0]  funct;
    logic [4:0]  rd;
    logic        xd;
    logic [63:0] rs1;
    logic [63:0] rs2;
  } cmd_t;

  cmd_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Mid-cycle monitor: the handshakes seen here complete at the next rising edge.
  always @(negedge clock) begin
    cmd_t e;
    if (!reset || flush) begin
      sb.delete();
    end else begin
      if (acc_cmd_valid && acc_cmd_ready) begin
        if (sb.size() == 0) begin
          check("pop_unexpected", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          $display("issue funct=%0d rd=%0d xd=%0d rs1=0x%0h", acc_cmd_funct, acc_cmd_rd, acc_cmd_xd, acc_cmd_rs1);
          check("sb_funct", 64'(acc_cmd_funct), 64'(e.funct));
          check("sb_rd",    64'(acc_cmd_rd),    64'(e.rd));
          check("sb_xd",    64'(acc_cmd_xd),    64'(e.xd));
          check("sb_rs1",   acc_cmd_rs1,        e.rs1);
          check("sb_rs2",   acc_cmd_rs2,        e.rs2);
        end
      end
      if (cpu_cmd_valid && cpu_cmd_ready)
        sb.push_back({cpu_cmd_funct, cpu_cmd_rd, cpu_cmd_xd, cpu_cmd_rs1, cpu_cmd_rs2});
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_cmd(input int f, input int r, input logic x, input logic [63:0] a);
    cpu_cmd_valid = 1'b1;
    cpu_cmd_funct = 7'(f);
    cpu_cmd_rd    = 5'(r);
    cpu_cmd_xd    = x;
    cpu_cmd_rs1   = a;
    cpu_cmd_rs2   = ~a;
  endtask

  initial begin
    cpu_cmd_valid = 0; cpu_cmd_funct = 0; cpu_cmd_rd = 0; cpu_cmd_xd = 0;
    cpu_cmd_rs1 = 0; cpu_cmd_rs2 = 0; acc_cmd_ready = 0;
    acc_resp_valid = 0; acc_resp_ready = 0; flush = 0;

    @(negedge clock);
    check("rst_ready",  64'(cpu_cmd_ready), 64'd1);
    check("rst_valid",  64'(acc_cmd_valid), 64'd0);
    check("rst_busy",   64'(busy), 64'd0);
    check("rst_level",  64'(level), 64'd0);
    check("rst_out",    64'(outstanding), 64'd0);
    check("rst_uflow",  64'(resp_underflow), 64'd0);
    check("rst_rs1",    acc_cmd_rs1, 64'd0);
    tick(); reset = 1'b1;

    // basic pass-through
    drive_cmd(1, 5, 1'b1, 64'hA); acc_cmd_ready = 1;
    @(negedge clock);
    check("t1_ready", 64'(cpu_cmd_ready), 64'd1);
    check("t1_nobypass", 64'(acc_cmd_valid), 64'd0);
    tick(); cpu_cmd_valid = 0;
    @(negedge clock);
    check("t1_valid", 64'(acc_cmd_valid), 64'd1);
    check("t1_rd", 64'(acc_cmd_rd), 64'd5);
    check("t1_level", 64'(level), 64'd1);
    tick();
    @(negedge clock);
    check("t1_out", 64'(outstanding), 64'd1);
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_level0", 64'(level), 64'd0);
    tick(); acc_resp_valid = 1; acc_resp_ready = 1;
    tick(); acc_resp_valid = 0;
    @(negedge clock);
    check("t1_out0", 64'(outstanding), 64'd0);
    check("t1_idle", 64'(busy), 64'd0);

    // fill and order
    tick(); acc_cmd_ready = 0;
    for (int k = 1; k <= 4; k++) begin
      drive_cmd(0, k, 1'b0, 64'(k));
      @(negedge clock);
      check("t2_ready", 64'(cpu_cmd_ready), 64'd1);
      tick();
    end
    drive_cmd(0, 5, 1'b0, 64'd5);
    @(negedge clock);
    check("t2_full", 64'(cpu_cmd_ready), 64'd0);
    check("t2_level4", 64'(level), 64'd4);
    tick(); acc_cmd_ready = 1;
    @(negedge clock);
    check("t2_nopopready", 64'(cpu_cmd_ready), 64'd0);
    check("t2_head1", 64'(acc_cmd_rd), 64'd1);
    tick();
    @(negedge clock);
    check("t2_reopen", 64'(cpu_cmd_ready), 64'd1);
    check("t2_head2", 64'(acc_cmd_rd), 64'd2);
    tick(); cpu_cmd_valid = 0;
    check("t2_level_pp", 64'(level), 64'd3);
    for (int k = 3; k <= 5; k++) begin
      @(negedge clock);
      check("t2_valid", 64'(acc_cmd_valid), 64'd1);
      check("t2_order", 64'(acc_cmd_rd), 64'(k));
      tick();
    end
    @(negedge clock);
    check("t2_empty", 64'(acc_cmd_valid), 64'd0);

    // outstanding limit
    tick(); acc_cmd_ready = 0;
    for (int k = 0; k < 3; k++) begin
      drive_cmd(2, 10 + k, 1'b1, 64'(100 + k));
      tick();
    end
    cpu_cmd_valid = 0; acc_cmd_ready = 1;
    @(negedge clock);
    check("t3_head10", 64'(acc_cmd_rd), 64'd10);
    tick();
    @(negedge clock);
    check("t3_head11", 64'(acc_cmd_rd), 64'd11);
    tick();
    @(negedge clock);
    check("t3_blocked", 64'(acc_cmd_valid), 64'd0);
    check("t3_out2", 64'(outstanding), 64'd2);
    check("t3_level1", 64'(level), 64'd1);
    tick(); acc_resp_valid = 1;
    @(negedge clock);
    check("t3_still_blocked", 64'(acc_cmd_valid), 64'd0);
    tick(); acc_resp_valid = 0;
    @(negedge clock);
    check("t3_freed", 64'(acc_cmd_valid), 64'd1);
    check("t3_head12", 64'(acc_cmd_rd), 64'd12);
    tick();
    @(negedge clock);
    check("t3_out2b", 64'(outstanding), 64'd2);
    tick(); drive_cmd(3, 13, 1'b0, 64'd113);
    tick(); cpu_cmd_valid = 0;
    @(negedge clock);
    check("t3_xd0_issue", 64'(acc_cmd_valid), 64'd1);
    check("t3_xd0_out", 64'(outstanding), 64'd2);
    tick(); acc_resp_valid = 1;
    tick(); tick(); acc_resp_valid = 0;
    @(negedge clock);
    check("t3_drained", 64'(outstanding), 64'd0);

    // simultaneous push, xd=1 pop and response
    tick(); drive_cmd(4, 19, 1'b1, 64'd119);
    tick(); cpu_cmd_valid = 0;
    tick(); acc_cmd_ready = 0;
    drive_cmd(4, 20, 1'b1, 64'd120); tick();
    drive_cmd(4, 21, 1'b1, 64'd121); tick();
    cpu_cmd_valid = 0;
    @(negedge clock);
    check("t4_level2", 64'(level), 64'd2);
    check("t4_out1", 64'(outstanding), 64'd1);
    tick(); drive_cmd(5, 22, 1'b0, 64'd122); acc_cmd_ready = 1; acc_resp_valid = 1;
    @(negedge clock);
    check("t4_issuable", 64'(acc_cmd_valid), 64'd1);
    tick(); cpu_cmd_valid = 0; acc_cmd_ready = 0; acc_resp_valid = 0;
    @(negedge clock);
    check("t4_level", 64'(level), 64'd2);
    check("t4_out", 64'(outstanding), 64'd1);
    check("t4_head21", 64'(acc_cmd_rd), 64'd21);

    // flush and underflow
    tick(); drive_cmd(6, 23, 1'b0, 64'd123);
    tick(); cpu_cmd_valid = 0;
    @(negedge clock);
    check("t5_level3", 64'(level), 64'd3);
    tick(); drive_cmd(6, 24, 1'b0, 64'd124); flush = 1;
    tick(); cpu_cmd_valid = 0; flush = 0;
    @(negedge clock);
    check("t5_flushed", 64'(level), 64'd0);
    check("t5_novalid", 64'(acc_cmd_valid), 64'd0);
    check("t5_out_kept", 64'(outstanding), 64'd1);
    check("t5_busy", 64'(busy), 64'd1);
    tick(); acc_resp_valid = 1;
    tick(); acc_resp_valid = 0;
    @(negedge clock);
    check("t5_out0", 64'(outstanding), 64'd0);
    check("t5_nouflow", 64'(resp_underflow), 64'd0);
    tick(); acc_resp_valid = 1;
    tick(); acc_resp_valid = 0;
    @(negedge clock);
    check("t5_uflow", 64'(resp_underflow), 64'd1);
    check("t5_out_floor", 64'(outstanding), 64'd0);
    tick();
    @(negedge clock);
    check("t5_uflow_sticky", 64'(resp_underflow), 64'd1);

    // reset mid-operation
    tick(); acc_cmd_ready = 1; acc_resp_ready = 0;
    drive_cmd(7, 30, 1'b1, 64'd130); tick();
    drive_cmd(7, 31, 1'b1, 64'd131); tick();
    drive_cmd(7, 32, 1'b1, 64'd132); tick();
    drive_cmd(7, 33, 1'b0, 64'd133); tick();
    drive_cmd(7, 34, 1'b0, 64'd134); tick();
    cpu_cmd_valid = 0;
    @(negedge clock);
    check("t6_level3", 64'(level), 64'd3);
    check("t6_out2", 64'(outstanding), 64'd2);
    check("t6_sb_depth", 64'(sb.size()), 64'd3);
    #1 reset = 1'b0;
    #1;
    check("t6_ready", 64'(cpu_cmd_ready), 64'd1);
    check("t6_valid", 64'(acc_cmd_valid), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_level", 64'(level), 64'd0);
    check("t6_out", 64'(outstanding), 64'd0);
    check("t6_uflow", 64'(resp_underflow), 64'd0);
    check("t6_rd", 64'(acc_cmd_rd), 64'd0);
`ifdef RCQ_STATS_EN
    check("t6_stat_cmds", 64'(stat_cmds), 64'd0);
    check("t6_stat_stall", 64'(stat_stall_cycles), 64'd0);
`endif
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
